// File: rtl/alu_muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// A transfer happens on a rising edge where valid and ready are both high; the sender holds
// valid and its payload stable until then, and ready may not depend on the same side's valid.
interface alu_muldiv_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_res;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixed up on the final iteration.
module alu_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  alu_muldiv_iter_if.slave    bus,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [XLEN-1:0]    opb_q, res_q;
  logic [2*XLEN-1:0]  acc_q, acc_nx;
  logic               neg_q;
  logic [CW-1:0]      cnt_q;

  logic               a_sgn, b_sgn, neg_a, neg_b, res_neg;
  logic               b_zero, ovf, special, accept;
  logic [XLEN-1:0]    mag_a, mag_b, special_res, sel, final_res;
  logic [XLEN:0]      sum_m, r_sh, diff;
  logic [2*XLEN-1:0]  mul_nx, div_nx, prod_s;

  // Operand preparation for the op being offered this cycle.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.in_op)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   a_sgn = 1'b1;
      default:                ;
    endcase
    neg_a   = a_sgn & bus.in_a[XLEN-1];
    neg_b   = b_sgn & bus.in_b[XLEN-1];
    mag_a   = neg_a ? -bus.in_a : bus.in_a;
    mag_b   = neg_b ? -bus.in_b : bus.in_b;
    // Remainder follows the dividend; product and quotient follow the operand signs.
    res_neg = (bus.in_op[2] && bus.in_op[1]) ? neg_a : (neg_a ^ neg_b);
    b_zero  = (bus.in_b == '0);
    ovf     = bus.in_op[2] && !bus.in_op[0] &&
              (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_b == '1);
    special = bus.in_op[2] && (b_zero || ovf);
    if (b_zero)
      special_res = bus.in_op[1] ? bus.in_a : '1;
    else
      special_res = bus.in_op[1] ? '0 : bus.in_a;
  end

  // One iteration of either algorithm on the accumulator {hi, lo}.
  always_comb begin
    sum_m  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_nx = {sum_m, acc_q[XLEN-1:1]};
    r_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff   = r_sh - {1'b0, opb_q};
    if (diff[XLEN])
      div_nx = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      div_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_nx = op_q[2] ? div_nx : mul_nx;
    prod_s = neg_q ? -acc_nx : acc_nx;
    sel    = op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    if (!op_q[2])
      final_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      final_res = neg_q ? -sel : sel;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        accept   = 1'b1;
        state_nx = special ? S_DONE : S_BUSY;
      end
      S_BUSY: if (cnt_q == CW'(1)) state_nx = S_DONE;
      S_DONE: if (bus.out_ready)   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx = S_IDLE;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q  <= '0;
      tag_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= bus.in_op;
      tag_q <= bus.in_tag;
      opb_q <= mag_b;
      acc_q <= {{XLEN{1'b0}}, mag_a};
      neg_q <= res_neg;
      cnt_q <= CW'(XLEN);
      if (special) res_q <= special_res;
    end else if (state == S_BUSY) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) res_q <= final_res;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_res   = res_q;
  assign bus.out_tag   = tag_q;
  assign dbg_state     = state;
endmodule
